psum_gbf_nbank: RTL and testbench

PSUM_GBF_NBANK -- requirements
Module: psum_gbf_nbank

---
 rtl/psum_gbf_nbank_if.sv | 25 ++
 rtl/psum_gbf_nbank.sv | 157 +++++++++++++++
 tb/tb_psum_gbf_nbank.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/psum_gbf_nbank_if.sv
// Request/response bus of the psum global buffer: write and accumulate
// requests into the compute bank, and registered reads from the drain bank.
interface psum_gbf_nbank_if #(
  parameter int DATA_W = 512,
  parameter int ADDR_W = 5
);
  logic              w_en;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;
  logic              w_acc;
  logic              r_en;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;

  modport master (
    output w_en, w_addr, w_data, w_acc, r_en, r_addr,
    input  r_data, r_valid
  );

  modport slave (
    input  w_en, w_addr, w_data, w_acc, r_en, r_addr,
    output r_data, r_valid
  );
endinterface

// File: rtl/psum_gbf_nbank.sv
// N-bank partial-sum buffer with rotating compute/drain roles and a 2-stage
// lane-wise accumulate. Define PSUM_GBF_SAT_EN to saturate lane sums instead of wrapping.
module psum_gbf_nbank #(
  parameter int OUT_BITWIDTH  = 16,
  parameter int LANES         = 32,
  parameter int ADDR_BITWIDTH = 5,
  parameter int DEPTH         = 32,
  parameter int NUM_BANK      = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  psum_gbf_nbank_if.slave             bus,
  input  logic                        swap,
  input  logic                        init_en,
  output logic                        busy,
  output logic [$clog2(NUM_BANK)-1:0] wbank_id,
  output logic [$clog2(NUM_BANK)-1:0] rbank_id
);
  localparam int DW    = LANES * OUT_BITWIDTH;
  localparam int BID_W = $clog2(NUM_BANK);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_BITWIDTH:0] DEPTH_W   = (ADDR_BITWIDTH + 1)'(DEPTH);
  localparam logic [BID_W-1:0]       LAST_BANK = BID_W'(NUM_BANK - 1);
  localparam logic [IDX_W-1:0]       LAST_ADDR = IDX_W'(DEPTH - 1);

  typedef enum logic {S_IDLE, S_CLEAR} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   clr_addr_q, clr_addr_d;
  logic [BID_W-1:0]   wbank_q, wbank_d, rbank_q, rbank_d;
  logic               p_valid_q;
  logic [BID_W-1:0]   p_bank_q;
  logic [IDX_W-1:0]   p_addr_q;
  logic [DW-1:0]      p_sum_q, p_sum_d;
  logic               r_valid_q;
  logic [DW-1:0]      r_data_q, r_data_d;
  logic [DW-1:0]      mem_q [NUM_BANK][DEPTH];

  logic               w_in_range, r_in_range, acc_go, ow_go;
  logic [IDX_W-1:0]   w_idx, r_idx;
  logic [DW-1:0]      stored;

  function automatic logic [DW-1:0] lane_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW-1:0]           s;
    logic [OUT_BITWIDTH-1:0] x, y, z;
    s = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      x = a[i*OUT_BITWIDTH +: OUT_BITWIDTH];
      y = b[i*OUT_BITWIDTH +: OUT_BITWIDTH];
      z = x + y;
`ifdef PSUM_GBF_SAT_EN
      // Signed overflow only when both operands share a sign the result lacks.
      if (x[OUT_BITWIDTH-1] == y[OUT_BITWIDTH-1] && z[OUT_BITWIDTH-1] != x[OUT_BITWIDTH-1])
        z = x[OUT_BITWIDTH-1] ? {1'b1, {(OUT_BITWIDTH-1){1'b0}}} : {1'b0, {(OUT_BITWIDTH-1){1'b1}}};
`endif
      s[i*OUT_BITWIDTH +: OUT_BITWIDTH] = z;
    end
    return s;
  endfunction

  always_comb begin
    w_in_range = {1'b0, bus.w_addr} < DEPTH_W;
    r_in_range = {1'b0, bus.r_addr} < DEPTH_W;
    w_idx      = w_in_range ? bus.w_addr[IDX_W-1:0] : '0;
    r_idx      = r_in_range ? bus.r_addr[IDX_W-1:0] : '0;
    acc_go     = (state_q == S_IDLE) && bus.w_en && w_in_range && bus.w_acc;
    ow_go      = (state_q == S_IDLE) && bus.w_en && w_in_range && !bus.w_acc;

    // The pending stage-2 sum is newer than memory for its bank/address.
    if (p_valid_q && p_bank_q == wbank_q && p_addr_q == w_idx)
      stored = p_sum_q;
    else
      stored = mem_q[wbank_q][w_idx];
    p_sum_d = lane_add(stored, bus.w_data);

    r_data_d = r_data_q;
    if (bus.r_en) begin
      if (!r_in_range)
        r_data_d = '0;
      else if (p_valid_q && p_bank_q == rbank_q && p_addr_q == r_idx)
        r_data_d = p_sum_q;
      else
        r_data_d = mem_q[rbank_q][r_idx];
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    wbank_d    = wbank_q;
    rbank_d    = rbank_q;
    case (state_q)
      S_IDLE: begin
        if (swap) begin
          wbank_d = (wbank_q == LAST_BANK) ? '0 : wbank_q + 1'b1;
          rbank_d = wbank_q;
        end
        if (init_en) begin
          state_d    = S_CLEAR;
          clr_addr_d = '0;
        end
      end
      S_CLEAR: begin
        clr_addr_d = clr_addr_q + 1'b1;
        if (clr_addr_q == LAST_ADDR)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      clr_addr_q <= '0;
      wbank_q    <= '0;
      rbank_q    <= LAST_BANK;
      p_valid_q  <= 1'b0;
      p_bank_q   <= '0;
      p_addr_q   <= '0;
      p_sum_q    <= '0;
      r_valid_q  <= 1'b0;
      r_data_q   <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      wbank_q    <= wbank_d;
      rbank_q    <= rbank_d;
      p_valid_q  <= acc_go;
      if (acc_go) begin
        p_bank_q <= wbank_q;
        p_addr_q <= w_idx;
        p_sum_q  <= p_sum_d;
      end
      r_valid_q  <= bus.r_en;
      r_data_q   <= r_data_d;
    end
  end

  // Later writers override earlier ones to the same word: stage-2 sum, then overwrite, then clear.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (p_valid_q)
        mem_q[p_bank_q][p_addr_q] <= p_sum_q;
      if (ow_go)
        mem_q[wbank_q][w_idx] <= bus.w_data;
      if (state_q == S_CLEAR)
        mem_q[wbank_q][clr_addr_q] <= '0;
    end
  end

  assign bus.r_data  = r_data_q;
  assign bus.r_valid = r_valid_q;
  assign busy        = (state_q == S_CLEAR);
  assign wbank_id    = wbank_q;
  assign rbank_id    = rbank_q;
endmodule

// File: tb/tb_psum_gbf_nbank.sv
// Bench for psum_gbf_nbank: array reference model plus a read scoreboard
// popped by an independent monitor whenever r_valid is seen.
module tb_psum_gbf_nbank;
  localparam int OW = 16, LN = 32, AW = 6, DEPTH = 32, NB = 3;
  localparam int DW = OW * LN, BW = $clog2(NB);
  localparam int MAXV = (1 << (OW - 1)) - 1, MINV = -(1 << (OW - 1));

  logic          clk = 1'b0, rst_n = 1'b0, swap = 1'b0, init_en = 1'b0, busy;
  logic [BW-1:0] wbank_id, rbank_id;

  psum_gbf_nbank_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  psum_gbf_nbank #(
    .OUT_BITWIDTH(OW), .LANES(LN), .ADDR_BITWIDTH(AW), .DEPTH(DEPTH), .NUM_BANK(NB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .swap(swap), .init_en(init_en),
    .busy(busy), .wbank_id(wbank_id), .rbank_id(rbank_id)
  );

  always #5 clk = ~clk;

  typedef struct { logic [DW-1:0] data; int due; } exp_t;
  exp_t          sb[$];
  logic [DW-1:0] mdl [NB][DEPTH];
  logic [DW-1:0] last_rd = '0;
  int wb, rb, clr_left, clr_idx, clr_bank;
  int n_cmp = 0, n_err = 0, cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_w(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_i(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] ref_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW-1:0] s;
    int x, y, t;
    s = '0;
    for (int i = 0; i < LN; i++) begin
      x = $signed(a[i*OW +: OW]);
      y = $signed(b[i*OW +: OW]);
      t = x + y;
`ifdef PSUM_GBF_SAT_EN
      if (t > MAXV) t = MAXV;
      if (t < MINV) t = MINV;
`endif
      s[i*OW +: OW] = t[OW-1:0];
    end
    return s;
  endfunction

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    w = '0;
    for (int i = 0; i < LN; i++) begin
      case ($urandom % 4)
        0:       w[i*OW +: OW] = 16'h7FFF;
        1:       w[i*OW +: OW] = 16'h8000;
        2:       w[i*OW +: OW] = ($urandom % 2 == 0) ? 16'h0001 : 16'hFFFF;
        default: w[i*OW +: OW] = 16'($urandom);
      endcase
    end
    return w;
  endfunction

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom % 8 == 0) return AW'($urandom_range(DEPTH, (1 << AW) - 1));
    return AW'($urandom_range(0, 7));
  endfunction

  task automatic set_idle();
    bus.w_en = 1'b0; bus.w_acc = 1'b0; bus.w_addr = '0; bus.w_data = '0;
    bus.r_en = 1'b0; bus.r_addr = '0; swap = 1'b0; init_en = 1'b0;
  endtask

  // One clock of the currently driven requests; the model applies them in program order.
  task automatic tick(input bit use_lit = 1'b0, input logic [DW-1:0] lit = '0);
    exp_t e;
    int   wa;
    if (bus.r_en) begin
      if (use_lit) e.data = lit;
      else if (int'(bus.r_addr) < DEPTH) e.data = mdl[rb][int'(bus.r_addr)];
      else e.data = '0;
      e.due = cyc + 1;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    wa = int'(bus.w_addr);
    if (!rst_n) begin
      clr_left = 0;
    end else if (clr_left > 0) begin
      mdl[clr_bank][clr_idx] = '0;
      clr_idx++;
      clr_left--;
    end else begin
      if (bus.w_en && wa < DEPTH)
        mdl[wb][wa] = bus.w_acc ? ref_add(mdl[wb][wa], bus.w_data) : bus.w_data;
      if (swap) begin
        rb = wb;
        wb = (wb + 1) % NB;
      end
      if (init_en) begin
        clr_left = DEPTH;
        clr_idx  = 0;
        clr_bank = wb;
      end
    end
    chk_i("busy", int'(busy), (clr_left > 0) ? 1 : 0);
    chk_i("wbank_id", int'(wbank_id), wb);
    chk_i("rbank_id", int'(rbank_id), rb);
    set_idle();
  endtask

  always @(posedge clk) begin : monitor
    exp_t e;
    #2;
    if (bus.r_valid) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL r_valid_unexpected: got r_valid=1, expected no pending read");
      end else begin
        e = sb.pop_front();
        chk_i("r_latency", cyc, e.due);
        chk_w("r_data", bus.r_data, e.data);
        last_rd = e.data;
      end
    end else begin
      chk_w("r_data_hold", bus.r_data, last_rd);
    end
  end

  initial begin
    logic [DW-1:0] lit9, lit10, d;
    int target;
    set_idle();
    wb = 0; rb = NB - 1; clr_left = 0; clr_idx = 0; clr_bank = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_i("rst_busy", int'(busy), 0);
    chk_i("rst_wbank", int'(wbank_id), 0);
    chk_i("rst_rbank", int'(rbank_id), NB - 1);
    chk_i("rst_r_valid", int'(bus.r_valid), 0);
    chk_w("rst_r_data", bus.r_data, '0);
    rst_n = 1'b1;

    // Clear every bank; junk requests during CLEAR must be ignored.
    for (int b = 0; b < NB; b++) begin
      init_en = 1'b1;
      tick();
      for (int k = 0; k < DEPTH; k++) begin
        bus.w_en = 1'($urandom); bus.w_acc = 1'($urandom);
        bus.w_addr = rand_addr(); bus.w_data = rand_word();
        swap = 1'($urandom); init_en = 1'($urandom);
        tick();
      end
      swap = 1'b1;
      tick();
    end

    // Four back-to-back accumulates of 1, swap right after, read back 4.
    init_en = 1'b1;
    tick();
    repeat (DEPTH) tick();
    for (int k = 0; k < 4; k++) begin
      bus.w_en = 1'b1; bus.w_acc = 1'b1; bus.w_addr = AW'(3); bus.w_data = {LN{16'h0001}};
      tick();
    end
    swap = 1'b1;
    tick();
    bus.r_en = 1'b1; bus.r_addr = AW'(3);
    tick(1'b1, {LN{16'h0004}});

    // Accumulate then swap next cycle; old bank holds the sum, new bank untouched.
    bus.w_en = 1'b1; bus.w_acc = 1'b1; bus.w_addr = AW'(5); bus.w_data = rand_word();
    tick();
    swap = 1'b1;
    tick();
    bus.r_en = 1'b1; bus.r_addr = AW'(5);
    tick();
    swap = 1'b1;
    tick();
    bus.r_en = 1'b1; bus.r_addr = AW'(5);
    tick(1'b1, '0);

    // Accumulate and swap together, read the in-flight address at once.
    bus.w_en = 1'b1; bus.w_acc = 1'b1; bus.w_addr = AW'(7); bus.w_data = rand_word();
    swap = 1'b1;
    tick();
    bus.r_en = 1'b1; bus.r_addr = AW'(7);
    tick();

    // Lane overflow boundaries.
`ifdef PSUM_GBF_SAT_EN
    lit9 = {LN{16'h7FFF}}; lit10 = {LN{16'h8000}};
`else
    lit9 = {LN{16'h8000}}; lit10 = {LN{16'h7FFF}};
`endif
    bus.w_en = 1'b1; bus.w_addr = AW'(9); bus.w_data = {LN{16'h7FFF}};
    tick();
    bus.w_en = 1'b1; bus.w_acc = 1'b1; bus.w_addr = AW'(9); bus.w_data = {LN{16'h0001}};
    tick();
    bus.w_en = 1'b1; bus.w_addr = AW'(10); bus.w_data = {LN{16'h8000}};
    tick();
    bus.w_en = 1'b1; bus.w_acc = 1'b1; bus.w_addr = AW'(10); bus.w_data = {LN{16'hFFFF}};
    tick();
    swap = 1'b1;
    tick();
    bus.r_en = 1'b1; bus.r_addr = AW'(9);
    tick(1'b1, lit9);
    bus.r_en = 1'b1; bus.r_addr = AW'(10);
    tick(1'b1, lit10);
    bus.r_en = 1'b1; bus.r_addr = AW'(40);
    bus.w_en = 1'b1; bus.w_addr = AW'(45); bus.w_data = rand_word();
    tick(1'b1, '0);

    // Fill the compute bank, start a clear, reset at clear address 10.
    for (int a = 0; a < 16; a++) begin
      d = rand_word();
      bus.w_en = 1'b1; bus.w_addr = AW'(a); bus.w_data = d;
      tick();
    end
    init_en = 1'b1;
    tick();
    repeat (10) tick();
    target = clr_bank;
    chk_i("clr_progress", clr_idx, 10);
    rst_n = 1'b0;
    sb.delete();
    last_rd = '0;
    wb = 0; rb = NB - 1; clr_left = 0;
    #1;
    chk_i("midclr_busy", int'(busy), 0);
    chk_i("midclr_wbank", int'(wbank_id), 0);
    chk_i("midclr_rbank", int'(rbank_id), NB - 1);
    chk_i("midclr_r_valid", int'(bus.r_valid), 0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < NB && rb != target; k++) begin
      swap = 1'b1;
      tick();
    end
    for (int a = 0; a < 16; a++) begin
      bus.r_en = 1'b1; bus.r_addr = AW'(a);
      if (a < 10) tick(1'b1, '0);
      else tick();
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      bus.w_en = 1'($urandom); bus.w_acc = 1'($urandom);
      bus.w_addr = rand_addr(); bus.w_data = rand_word();
      bus.r_en = 1'($urandom); bus.r_addr = rand_addr();
      swap = ($urandom % 8 == 0);
      init_en = ($urandom % 64 == 0);
      tick();
    end

    repeat (4) tick();
    chk_i("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
